// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    FINISH
  } loader_state_t;

endpackage

// File: rtl/word_packer.sv
// Assembles little-endian bytes into a 32-bit word; word_full flags the byte
// that completes the word in the same cycle it is accepted.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d  = '0;
      word_d = '0;
    end else if (byte_en) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_in;
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word      = word_q;
  assign word_full = byte_en && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory at consecutive word addresses while
// holding the core in reset; reports completion, errors and a word checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [WORD_W-1:0] checksum
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [WORD_W-1:0] csum_q, csum_d;
  logic              err_q, err_d;

  logic              pk_clear;
  logic              byte_en;
  logic [WORD_W-1:0] word;
  logic              word_full;

  assign byte_en = s_valid && s_ready;

  word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .byte_en   (byte_en),
    .byte_in   (s_data),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_d  = state_q;
    wc_d     = wc_q;
    addr_d   = addr_q;
    csum_d   = csum_q;
    err_d    = err_q;
    pk_clear = 1'b0;
    case (state_q)
      IDLE: begin
        pk_clear = 1'b1;
        if (start) begin
          if (word_count > DEPTH) begin
            err_d = 1'b1;
          end else begin
            wc_d    = word_count;
            err_d   = 1'b0;
            csum_d  = '0;
            addr_d  = '0;
            state_d = (word_count == '0) ? FINISH : COLLECT;
          end
        end
      end
      COLLECT: begin
        // abort wins over a word completing in the same cycle
        if (abort) begin
          pk_clear = 1'b1;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else if (word_full) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        // the write on the bus this cycle lands even if abort is raised
        csum_d = csum_q + word;
        addr_d = addr_q + 1'b1;
        if (abort) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (addr_d == wc_q) begin
          state_d = FINISH;
        end else begin
          state_d = COLLECT;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wc_q    <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      err_q   <= err_d;
    end
  end

  assign s_ready   = (state_q == COLLECT);
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = addr_q[ADDR_W-1:0];
  assign mem_wdata = (state_q == WRITE) ? word : '0;
  assign busy      = (state_q != IDLE);
  assign cpu_hold  = busy;
  assign done      = (state_q == FINISH);
  assign error     = err_q;
  assign checksum  = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed, table-driven and random loads checked
// against a word-level model of the stream, writes and checksum.
module tb_imem_loader;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LOGN   = DEPTH + 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic              abort = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = '0;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [31:0]       checksum;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run = 0;
  int n_fail = 0;

  logic [7:0]        bs   [0:4*LOGN-1];
  logic [ADDR_W-1:0] wr_a [0:LOGN-1];
  logic [31:0]       wr_d [0:LOGN-1];
  int                wr_n, done_n, done_cyc, st_cyc, busy_cnt, inv_bad;
  logic [31:0]       done_chk;
  logic              prev_we = 1'b0;
  logic [31:0]       model_chk = '0;
  int                model_err = 0;

  typedef struct {
    int wc; int gap; int ab_byte; int ab_wr;
    int exp_wr; int exp_err; int exp_done; int exp_lat;
  } vec_t;

  task automatic check(input string nm, input longint got, input longint exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    return {bs[4*i+3], bs[4*i+2], bs[4*i+1], bs[4*i]};
  endfunction

  task automatic tick();
    @(negedge clk);
    if (mem_we) begin
      if (wr_n < LOGN) begin
        wr_a[wr_n] = mem_addr;
        wr_d[wr_n] = mem_wdata;
      end
      wr_n++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
      done_chk = checksum;
    end
    if (busy) busy_cnt++;
    if ((mem_we && prev_we) || (cpu_hold != busy)) inv_bad++;
    prev_we = mem_we;
  endtask

  // gap < 0 toggles s_valid every other cycle; otherwise gap is the idle percentage
  task automatic run_load(input int wc, input int gap, input int ab_byte,
                          input int ab_wr, input int budget);
    int idx, n;
    bit stop, ab_pend, want;
    wr_n = 0; done_n = 0; done_cyc = -1; busy_cnt = 0;
    tick();
    start = 1'b1; word_count = (ADDR_W+1)'(wc); st_cyc = cyc;
    idx = 0; n = 0; stop = 0; ab_pend = 0;
    while (!stop && n < budget) begin
      tick();
      n++;
      start = 1'b0; abort = 1'b0; s_valid = 1'b0;
      if (ab_pend || done_n > 0) begin
        stop = 1;
      end else if (ab_wr >= 0 && mem_we && wr_n == ab_wr + 1) begin
        abort = 1'b1; ab_pend = 1;
      end else if (ab_byte >= 0 && idx == ab_byte && s_ready) begin
        s_valid = 1'b1; s_data = bs[idx]; abort = 1'b1; ab_pend = 1;
      end else begin
        want = (gap < 0) ? (n % 2 == 0) : ($urandom_range(99) >= gap);
        if (idx < 4*wc && want) begin
          s_valid = 1'b1; s_data = bs[idx];
          if (s_ready) idx++;
        end
      end
    end
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;
  endtask

  function automatic int model_writes(input int wc, input int ab_byte, input int ab_wr);
    if (wc > DEPTH) return 0;
    if (ab_byte >= 0) return ab_byte / 4;
    if (ab_wr >= 0) return ab_wr + 1;
    return wc;
  endfunction

  task automatic check_load(input string nm, input int wc, input int ab_byte,
                            input int ab_wr, input int exp_wr, input int exp_err,
                            input int exp_done, input int exp_lat);
    int bad;
    int mw;
    mw = model_writes(wc, ab_byte, ab_wr);
    if (wc > DEPTH) begin
      model_err = 1;
    end else begin
      model_err = (ab_byte >= 0 || ab_wr >= 0) ? 1 : 0;
      model_chk = '0;
      for (int i = 0; i < mw; i++) model_chk += word_of(i);
    end
    check({nm, " writes"}, wr_n, exp_wr);
    bad = 0;
    for (int i = 0; i < wr_n && i < LOGN; i++)
      if (wr_a[i] != i[ADDR_W-1:0] || wr_d[i] != word_of(i)) bad++;
    check({nm, " data/addr errors"}, bad, 0);
    check({nm, " done count"}, done_n, exp_done);
    if (exp_done > 0) check({nm, " checksum at done"}, done_chk, model_chk);
    if (exp_lat >= 0) check({nm, " latency"}, done_cyc - st_cyc, exp_lat);
    tick();
    check({nm, " checksum held"}, checksum, model_chk);
    check({nm, " error"}, error, exp_err);
    check({nm, " error model"}, error, model_err);
    check({nm, " busy after"}, busy, 0);
    if (wc > DEPTH) check({nm, " busy never rose"}, busy_cnt, 0);
  endtask

  vec_t tbl[10];

  initial begin
    int wc, gap, mode, ab_b, ab_w;

    tbl[0] = '{1,    0, -1, -1, 1, 0, 1, 6};
    tbl[1] = '{3,    0, -1, -1, 3, 0, 1, 16};
    tbl[2] = '{1,   -1, -1, -1, 1, 0, 1, -1};
    tbl[3] = '{0,    0, -1, -1, 0, 0, 1, 1};
    tbl[4] = '{4097, 0, -1, -1, 0, 1, 0, -1};
    tbl[5] = '{2,   30, -1, -1, 2, 0, 1, -1};
    tbl[6] = '{3,    0,  7, -1, 1, 1, 0, -1};
    tbl[7] = '{2,    0, -1, -1, 2, 0, 1, 11};
    tbl[8] = '{2,   20, -1,  1, 2, 1, 0, -1};
    tbl[9] = '{4,    0,  0, -1, 0, 1, 0, -1};

    wr_n = 0; done_n = 0; busy_cnt = 0; inv_bad = 0;

    repeat (3) tick();
    check("reset outputs",
          {s_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error, checksum}, 0);
    reset = 1'b0;
    tick();

    // directed two-word load from the documented byte stream
    {bs[0], bs[1], bs[2], bs[3]} = {8'h44, 8'h33, 8'h22, 8'h11};
    {bs[4], bs[5], bs[6], bs[7]} = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    run_load(2, 0, -1, -1, 60);
    check("dir word0", wr_d[0], 32'h11223344);
    check("dir word1", wr_d[1], 32'hAABBCCDD);
    check("dir checksum", done_chk, 32'hBBDE0021);
    check_load("dir", 2, -1, -1, 2, 0, 1, 11);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 64; i++) bs[i] = 8'($urandom);
      run_load(tbl[r].wc, tbl[r].gap, tbl[r].ab_byte, tbl[r].ab_wr, 30*4 + 40);
      check_load($sformatf("row%0d", r), tbl[r].wc, tbl[r].ab_byte, tbl[r].ab_wr,
                 tbl[r].exp_wr, tbl[r].exp_err, tbl[r].exp_done, tbl[r].exp_lat);
    end

    // reset during the first word: silent abort, error cleared, nothing written
    check("pre-reset error", error, 1);
    wr_n = 0;
    tick();
    start = 1'b1; word_count = 13'd2;
    tick();
    start = 1'b0; s_valid = 1'b1; s_data = bs[0];
    tick();
    s_data = bs[1];
    tick();
    s_valid = 1'b0; reset = 1'b1;
    tick();
    check("mid-load reset outputs",
          {s_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error, checksum}, 0);
    check("mid-load reset writes", wr_n, 0);
    reset = 1'b0; model_err = 0; model_chk = '0;
    tick();

    for (int r = 0; r < 12; r++) begin
      wc = $urandom_range(1, 8);
      gap = $urandom_range(0, 60);
      mode = $urandom_range(0, 2);
      ab_b = (mode == 1) ? $urandom_range(0, 4*wc - 1) : -1;
      ab_w = (mode == 2) ? $urandom_range(0, wc - 1) : -1;
      for (int i = 0; i < 4*wc; i++) bs[i] = 8'($urandom);
      run_load(wc, gap, ab_b, ab_w, 30*wc + 20);
      check_load($sformatf("rand%0d", r), wc, ab_b, ab_w,
                 model_writes(wc, ab_b, ab_w), (mode != 0) ? 1 : 0,
                 (mode == 0) ? 1 : 0, -1);
    end

    // full depth: last write lands at the top address with no wrap
    for (int i = 0; i < DEPTH; i++)
      {bs[4*i+3], bs[4*i+2], bs[4*i+1], bs[4*i]} = 32'hC0DE0000 + i;
    run_load(DEPTH, 0, -1, -1, 5*DEPTH + 20);
    check("full last addr", wr_a[DEPTH-1], DEPTH - 1);
    check_load("full", DEPTH, -1, -1, DEPTH, 0, 1, 5*DEPTH + 1);

    check("invariants (we back-to-back, hold!=busy)", inv_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Loads program words into the instruction memory from a byte-wide valid/ready stream, so the core fetches from writable storage instead of a hard-coded ROM image. Bytes arrive little-endian and are packed into 32-bit words. Each word is written once to consecutive word addresses starting at 0. While loading, the block holds the core in reset. It sits between the host/debug byte link and the write port of the instruction memory.

## Interface
Parameters:
- ADDR_W, 12, word-address width of the instruction memory (depth 2^ADDR_W words)

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  load request; sampled only in IDLE
- word_count  in  ADDR_W+1  words to load; sampled with start
- abort  in  1  cancel an active load
- s_valid  in  1  byte stream valid
- s_data  in  8  byte stream data
- s_ready  out  1  byte stream ready
- mem_we  out  1  instruction-memory write enable
- mem_addr  out  ADDR_W  word address of the write
- mem_wdata  out  32  write data
- busy  out  1  load in progress
- cpu_hold  out  1  holds the core in reset; equals busy
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky; cleared by the next accepted start
- checksum  out  32  sum mod 2^32 of all words written in the current or last load

## Operation
- Clock and reset are fixed: one clock, clk; reset is synchronous and active-high.
- FSM states: IDLE, COLLECT, WRITE, FINISH.
- IDLE:
  - If start=1 and word_count=0: go to FINISH.
  - If start=1 and word_count>2^ADDR_W: set error=1 and stay in IDLE; no writes.
  - If start=1 and word_count is otherwise valid: latch word_count, clear error, checksum and the address counter, then go to COLLECT.
- COLLECT:
  - s_ready=1.
  - A byte is accepted when s_valid&&s_ready.
  - Byte k (k=0..3) goes to bits [8k+7:8k].
  - After the 4th accepted byte, go to WRITE.
- WRITE:
  - mem_we=1, mem_addr=address counter, mem_wdata=packed word. All three are decoded from registered state and are stable for the whole cycle.
  - checksum += word.
  - Address counter increments.
  - If the word just written was number word_count, go to FINISH; otherwise go to COLLECT.
- FINISH: done=1 for exactly one cycle, then go to IDLE.
- abort in COLLECT or WRITE:
  - Go to IDLE at the next edge and set error=1.
  - The partial word is discarded.
  - A write already being presented in WRITE still completes.
  - abort has priority over the state transition, so a 4th byte accepted in the same cycle is never written.
- start while busy is ignored.
- Address arithmetic:
  - The counter is ADDR_W+1 bits wide; the compare is against the latched word_count.
  - mem_addr is the low ADDR_W bits. A load of exactly 2^ADDR_W words writes address 2^ADDR_W−1 last and never wraps.
- Reset values: state=IDLE, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, cpu_hold=0, done=0, error=0, checksum=0, byte index=0.
- Reset mid-load:
  - Aborts silently at the next edge with error=0.
  - Words already written stay in memory.

## Timing
- busy and cpu_hold rise the cycle after start is accepted and fall the cycle after FINISH.
- With s_valid held high, each word takes 5 cycles: 4 COLLECT cycles plus 1 WRITE cycle. s_ready=0 during WRITE.
- N words take 5N+1 cycles from start to done (5N cycles of COLLECT/WRITE plus 1 cycle of FINISH). For word_count=0, done pulses 1 cycle after start.
- mem_we is never high for two consecutive cycles.
- checksum is valid in the done cycle and holds until the next accepted start.

## Structure
- Package imem_loader_pkg holds:
  - the state enum type loader_state_t;
  - the localparam BYTES_PER_WORD=4;
  - the localparam WORD_W=32.
- One sub-module, word_packer, handles byte assembly:
  - byte index counter and 32-bit shift/insert register;
  - inputs: clk, reset, clear, byte_en, byte_in;
  - outputs: word, word_full.
- The top level holds the FSM, address counter, checksum and outputs.

## Test plan
- Directed load of 2 words, stream 44 33 22 11 DD CC BB AA with s_valid held high: writes 0x11223344 at address 0 and 0xAABBCCDD at address 1; done 11 cycles after start; checksum=0xBBDE0021.
- Gapped stream (s_valid toggled every other cycle), 1 word 0x00112233: exactly one mem_we pulse, at address 0; done only after the 4th accepted byte.
- word_count=0: no mem_we, done 1 cycle after start, error=0. word_count=4097 (ADDR_W=12): error=1, busy stays 0.
- abort asserted in the same cycle as the 4th byte of word 1: one write only (word 0); error=1; state IDLE next cycle. A following good start clears error.
- reset asserted after 2 bytes of word 0: all outputs 0 at the next edge; no write issued; error=0.
- Full-depth load of 4096 words with an incrementing pattern: last write at address 0xFFF; no wrap to 0; checksum matches the model.
